// File: rtl/command_decoder.sv
// rtl/command_decoder.sv - address/command byte-pair decoder driving a sensor request and a two-byte response
// Optional continuous-measurement mode is enabled by defining CONT_MODE_EN.
module command_decoder #(
  parameter int TIMEOUT = 2000
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       control,
  input  logic       sensor_done,
  input  logic       sensor_ok,
  input  logic [7:0] sensor_value,
  input  logic       tx_ready,
  output logic [4:0] sensor_sel,
  output logic [1:0] cmd_op,
  output logic       sensor_req,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       overrun
);

  localparam logic [2:0] GET_ADDR    = 3'd0;
  localparam logic [2:0] GET_CMD     = 3'd1;
  localparam logic [2:0] CHECK       = 3'd2;
  localparam logic [2:0] REQUEST     = 3'd3;
  localparam logic [2:0] WAIT_SENSOR = 3'd4;
  localparam logic [2:0] SEND_CODE   = 3'd5;
  localparam logic [2:0] SEND_VALUE  = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state_q, state_d;
  logic          control_q, control_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    value_q, value_d;
  logic [4:0]    sensor_sel_q, sensor_sel_d;
  logic [1:0]    cmd_op_q, cmd_op_d;
  logic          sensor_req_q, sensor_req_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          overrun_q, overrun_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       byte_event;
  logic       cmd_known;
  logic [1:0] op_decoded;
  logic       timer_expired;

  assign byte_event    = control & ~control_q;
  assign timer_expired = (timer_q == TW'(TIMEOUT - 1));

`ifdef CONT_MODE_EN
  logic cont_q, cont_d;
  logic err_resp;
  logic cont_set;

  assign cmd_known  = (cmd_q <= 8'd4);
  assign op_decoded = (cmd_q == 8'd3) ? 2'd1 : (cmd_q == 8'd4) ? 2'd2 : cmd_q[1:0];
  assign err_resp   = ((state_q == CHECK) && ((addr_q >= 8'd32) || !cmd_known)) ||
                      ((state_q == WAIT_SENSOR) && (sensor_done ? !sensor_ok : timer_expired));
  assign cont_set   = (state_q == CHECK) && (addr_q < 8'd32) && cmd_known && (cmd_q >= 8'd3);

  // A stray byte always cancels continuous mode, even in the cycle the flag would be set.
  always_comb begin
    cont_d = cont_q;
    if (cont_set) cont_d = 1'b1;
    if (err_resp) cont_d = 1'b0;
    if (byte_event && (state_q >= CHECK)) cont_d = 1'b0;
  end
`else
  assign cmd_known  = (cmd_q <= 8'd2);
  assign op_decoded = cmd_q[1:0];
`endif

  always_comb begin
    state_d      = state_q;
    control_d    = control;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    value_d      = value_q;
    sensor_sel_d = sensor_sel_q;
    cmd_op_d     = cmd_op_q;
    sensor_req_d = 1'b0;
    tx_byte_d    = tx_byte_q;
    tx_valid_d   = tx_valid_q;
    overrun_d    = byte_event && (state_q >= CHECK);
    timer_d      = '0;
    case (state_q)
      GET_ADDR: begin
        if (byte_event) begin
          addr_d  = data;
          state_d = GET_CMD;
        end
      end
      GET_CMD: begin
        if (byte_event) begin
          cmd_d   = data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (addr_q >= 8'd32) begin
          tx_byte_d  = 8'hE0;
          value_d    = addr_q;
          tx_valid_d = 1'b1;
          state_d    = SEND_CODE;
        end else if (cmd_known) begin
          sensor_sel_d = addr_q[4:0];
          cmd_op_d     = op_decoded;
          state_d      = REQUEST;
        end else begin
          tx_byte_d  = 8'hE1;
          value_d    = cmd_q;
          tx_valid_d = 1'b1;
          state_d    = SEND_CODE;
        end
      end
      REQUEST: begin
        sensor_req_d = 1'b1;
        state_d      = WAIT_SENSOR;
      end
      WAIT_SENSOR: begin
        // sensor_done is checked first so it wins over a coincident timeout.
        if (sensor_done) begin
          tx_byte_d  = sensor_ok ? {6'd0, cmd_op_q} : 8'hE2;
          value_d    = sensor_ok ? sensor_value : {3'd0, sensor_sel_q};
          tx_valid_d = 1'b1;
          state_d    = SEND_CODE;
        end else if (timer_expired) begin
          tx_byte_d  = 8'hE3;
          value_d    = {3'd0, sensor_sel_q};
          tx_valid_d = 1'b1;
          state_d    = SEND_CODE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SEND_CODE: begin
        if (tx_ready) begin
          tx_byte_d = value_q;
          state_d   = SEND_VALUE;
        end
      end
      SEND_VALUE: begin
        if (tx_ready) begin
          tx_byte_d  = 8'h00;
          tx_valid_d = 1'b0;
`ifdef CONT_MODE_EN
          state_d    = (cont_q && !byte_event) ? REQUEST : GET_ADDR;
`else
          state_d    = GET_ADDR;
`endif
        end
      end
      default: state_d = GET_ADDR;
    endcase
  end

  always_ff @(posedge clk_115200hz) begin
    if (reset) begin
      state_q      <= GET_ADDR;
      control_q    <= 1'b1;
      addr_q       <= 8'h00;
      cmd_q        <= 8'h00;
      value_q      <= 8'h00;
      sensor_sel_q <= 5'd0;
      cmd_op_q     <= 2'd0;
      sensor_req_q <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      timer_q      <= '0;
`ifdef CONT_MODE_EN
      cont_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      control_q    <= control_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      value_q      <= value_d;
      sensor_sel_q <= sensor_sel_d;
      cmd_op_q     <= cmd_op_d;
      sensor_req_q <= sensor_req_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
      overrun_q    <= overrun_d;
      timer_q      <= timer_d;
`ifdef CONT_MODE_EN
      cont_q       <= cont_d;
`endif
    end
  end

  assign sensor_sel = sensor_sel_q;
  assign cmd_op     = cmd_op_q;
  assign sensor_req = sensor_req_q;
  assign tx_byte    = tx_byte_q;
  assign tx_valid   = tx_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_command_decoder.sv
// tb/tb_command_decoder.sv - directed self-checking bench for command_decoder
// Continuous-mode scenario is exercised when CONT_MODE_EN is defined.
module tb_command_decoder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       control = 1'b0;
  logic       sensor_done = 1'b0;
  logic       sensor_ok = 1'b0;
  logic [7:0] sensor_value = 8'h00;
  logic       tx_ready = 1'b1;
  logic [4:0] sensor_sel;
  logic [1:0] cmd_op;
  logic       sensor_req;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       overrun;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] tx_q[$];
  int req_cnt = 0;
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  command_decoder #(.TIMEOUT(TO)) dut (
    .clk_115200hz(clk),
    .reset(reset),
    .data(data),
    .control(control),
    .sensor_done(sensor_done),
    .sensor_ok(sensor_ok),
    .sensor_value(sensor_value),
    .tx_ready(tx_ready),
    .sensor_sel(sensor_sel),
    .cmd_op(cmd_op),
    .sensor_req(sensor_req),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .overrun(overrun)
  );

  // Transfer / pulse monitor sampled mid-cycle, while inputs are stable.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
    if (sensor_req) req_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sensor_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tx_q.delete();
    req_cnt = 0;
    ovr_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    control = 1'b1;
    tick();
    control = 1'b0;
    tick();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (sensor_req) ok = 1'b1;
    end
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (tx_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic pulse_done(input logic ok_in, input logic [7:0] val);
    sensor_done = 1'b1;
    sensor_ok = ok_in;
    sensor_value = val;
    tick();
    sensor_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({sensor_sel, cmd_op, sensor_req, tx_byte, tx_valid, overrun} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: got sel=%0d op=%0d req=%b tx=%h v=%b ovr=%b, expected all zero",
               sensor_sel, cmd_op, sensor_req, tx_byte, tx_valid, overrun);
    end
    do_reset();
  endtask

  task automatic test_temperature();
    bit ok;
    do_reset();
    send_byte(8'h05);
    data = 8'h01;
    control = 1'b1;
    tick();
    control = 1'b0;
    tests_run++;
    if (sensor_req !== 1'b0) begin fails++; $display("FAIL req_edge1: got %b expected 0", sensor_req); end
    tick();
    tests_run++;
    if (sensor_req !== 1'b0) begin fails++; $display("FAIL req_edge2: got %b expected 0", sensor_req); end
    tick();
    tests_run++;
    if (sensor_req !== 1'b1 || sensor_sel !== 5'd5 || cmd_op !== 2'd1) begin
      fails++;
      $display("FAIL req_pulse: got req=%b sel=%0d op=%0d expected req=1 sel=5 op=1", sensor_req, sensor_sel, cmd_op);
    end
    pulse_done(1'b1, 8'h19);
    tests_run++;
    if (sensor_req !== 1'b0) begin fails++; $display("FAIL req_width: got %b expected 0", sensor_req); end
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'h01 || tx_q[1] !== 8'h19) begin
      fails++;
      $display("FAIL temp_tx: got n=%0d %h %h expected 01 19", tx_q.size(), tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_errors();
    bit ok;
    int r0;
    logic [7:0] addr_v[3] = '{8'h40, 8'h20, 8'h05};
    logic [7:0] cmd_v[3]  = '{8'h00, 8'h01, 8'h07};
    logic [7:0] code_v[3] = '{8'hE0, 8'hE0, 8'hE1};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      r0 = req_cnt;
      send_byte(addr_v[k]);
      send_byte(cmd_v[k]);
      wait_tx(2, ok);
      tests_run++;
      if (!ok || tx_q[0] !== code_v[k] || tx_q[1] !== (code_v[k] == 8'hE0 ? addr_v[k] : cmd_v[k]) || req_cnt != r0) begin
        fails++;
        $display("FAIL error_%0d: got n=%0d %h %h reqs=%0d expected %h and offending byte, no req",
                 k, tx_q.size(), tx_q[0], tx_q[1], req_cnt - r0, code_v[k]);
      end
    end
    do_reset();
    send_byte(8'h1F);
    send_byte(8'h02);
    wait_req(ok);
    tests_run++;
    if (!ok || sensor_sel !== 5'd31 || cmd_op !== 2'd2) begin
      fails++;
      $display("FAIL addr_31: got req_seen=%b sel=%0d op=%0d expected 1 31 2", ok, sensor_sel, cmd_op);
    end
    pulse_done(1'b0, 8'hAA);
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'hE2 || tx_q[1] !== 8'h1F) begin
      fails++;
      $display("FAIL sensor_fail: got n=%0d %h %h expected E2 1F", tx_q.size(), tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    do_reset();
    send_byte(8'h03);
    send_byte(8'h02);
    wait_req(ok);
    cnt = 0;
    while (!tx_valid && cnt < 200) begin
      tick();
      cnt++;
    end
    tests_run++;
    if (!ok || cnt != TO) begin
      fails++;
      $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TO);
    end
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'hE3 || tx_q[1] !== 8'h03) begin
      fails++;
      $display("FAIL timeout_tx: got n=%0d %h %h expected E3 03", tx_q.size(), tx_q[0], tx_q[1]);
    end
    do_reset();
    send_byte(8'h03);
    send_byte(8'h02);
    wait_req(ok);
    repeat (TO - 1) tick();
    pulse_done(1'b1, 8'h77);
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'h02 || tx_q[1] !== 8'h77) begin
      fails++;
      $display("FAIL timeout_race: got n=%0d %h %h expected 02 77", tx_q.size(), tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    do_reset();
    tx_ready = 1'b0;
    send_byte(8'h40);
    send_byte(8'h00);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_byte !== 8'hE0) stable = 1'b0;
      if (i == 3) begin data = 8'h99; control = 1'b1; end
      if (i == 4) control = 1'b0;
      tick();
    end
    tests_run++;
    if (!stable || tx_q.size() != 0) begin
      fails++;
      $display("FAIL hold_stable: got stable=%b transfers=%0d expected 1 0", stable, tx_q.size());
    end
    tests_run++;
    if (ovr_cnt != 1) begin fails++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ovr_cnt); end
    tx_ready = 1'b1;
    wait_tx(2, ok);
    repeat (5) tick();
    tests_run++;
    if (!ok || tx_q.size() != 2 || tx_q[0] !== 8'hE0 || tx_q[1] !== 8'h40 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL one_transfer: got n=%0d %h %h v=%b expected 2 E0 40 0", tx_q.size(), tx_q[0], tx_q[1], tx_valid);
    end
    send_byte(8'h05);
    send_byte(8'h07);
    wait_tx(4, ok);
    tests_run++;
    if (!ok || tx_q[2] !== 8'hE1 || tx_q[3] !== 8'h07) begin
      fails++;
      $display("FAIL realign: got n=%0d %h %h expected E1 07", tx_q.size(), tx_q[2], tx_q[3]);
    end
  endtask

  task automatic test_reset_control_high();
    bit ok;
    reset = 1'b1;
    data = 8'h55;
    control = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tx_q.delete();
    repeat (3) tick();
    control = 1'b0;
    tick();
    send_byte(8'h05);
    send_byte(8'h07);
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'hE1 || tx_q[1] !== 8'h07) begin
      fails++;
      $display("FAIL ctrl_through_reset: got n=%0d %h %h expected E1 07", tx_q.size(), tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    do_reset();
    tx_ready = 1'b0;
    send_byte(8'h40);
    send_byte(8'h00);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
      fails++;
      $display("FAIL reset_pending_tx: got v=%b tx=%h expected 0 00", tx_valid, tx_byte);
    end
    tx_ready = 1'b1;
    tick();
    send_byte(8'h40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tx_q.delete();
    send_byte(8'h05);
    send_byte(8'h07);
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'hE1 || tx_q[1] !== 8'h07) begin
      fails++;
      $display("FAIL reset_partial_pair: got n=%0d %h %h expected E1 07", tx_q.size(), tx_q[0], tx_q[1]);
    end
  endtask

  task automatic test_done_ignored();
    repeat (2) begin
      do_reset();
      pulse_done(1'b1, 8'h33);
      repeat (4) tick();
    end
    tests_run++;
    if (tx_valid !== 1'b0 || tx_q.size() != 0) begin
      fails++;
      $display("FAIL done_ignored: got v=%b transfers=%0d expected 0 0", tx_valid, tx_q.size());
    end
  endtask

`ifdef CONT_MODE_EN
  task automatic test_continuous();
    bit ok;
    bit good;
    int r0;
    do_reset();
    send_byte(8'h01);
    send_byte(8'h03);
    good = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req(ok);
      if (!ok || sensor_sel !== 5'd1 || cmd_op !== 2'd1) good = 1'b0;
      pulse_done(1'b1, 8'h30 + 8'(k));
      wait_tx(2 * (k + 1), ok);
      if (!ok || tx_q[2*k] !== 8'h01 || tx_q[2*k+1] !== 8'h30 + 8'(k)) good = 1'b0;
    end
    tests_run++;
    if (!good) begin fails++; $display("FAIL cont_repeat: got n=%0d transfers, expected 6 of 01/3k on sensor 1", tx_q.size()); end
    wait_req(ok);
    control = 1'b1;
    data = 8'hAA;
    tick();
    control = 1'b0;
    pulse_done(1'b1, 8'h50);
    wait_tx(8, ok);
    r0 = req_cnt;
    repeat (30) tick();
    tests_run++;
    if (!ok || tx_q[6] !== 8'h01 || tx_q[7] !== 8'h50 || ovr_cnt != 1 || req_cnt != r0) begin
      fails++;
      $display("FAIL cont_stop: got %h %h ovr=%0d extra_reqs=%0d expected 01 50 1 0",
               tx_q[6], tx_q[7], ovr_cnt, req_cnt - r0);
    end
    send_byte(8'h05);
    send_byte(8'h07);
    wait_tx(10, ok);
    tests_run++;
    if (!ok || tx_q[8] !== 8'hE1 || tx_q[9] !== 8'h07) begin
      fails++;
      $display("FAIL cont_realign: got %h %h expected E1 07", tx_q[8], tx_q[9]);
    end
  endtask
`else
  task automatic test_cont_rejected();
    bit ok;
    do_reset();
    send_byte(8'h05);
    send_byte(8'h03);
    wait_tx(2, ok);
    tests_run++;
    if (!ok || tx_q[0] !== 8'hE1 || tx_q[1] !== 8'h03) begin
      fails++;
      $display("FAIL cont_cmd_rejected: got n=%0d %h %h expected E1 03", tx_q.size(), tx_q[0], tx_q[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_temperature();
    test_errors();
    test_timeout();
    test_backpressure();
    test_reset_control_high();
    test_reset_abort();
    test_done_ignored();
`ifdef CONT_MODE_EN
    test_continuous();
`else
    test_cont_rejected();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
